// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central pipeline sequencer for the 5-stage core. It turns three kinds of
// disruption into freeze/flush controls for the stage registers:
//   * data hazards between the ID instruction and the EXE/MEM instructions
//     (behaviour depends on whether the forwarding unit is enabled),
//   * taken branches resolved in EXE,
//   * multi-cycle data-memory accesses, sequenced by a small IDLE/WAIT FSM
//     that talks to the memory controller over a start/ready handshake.
// It also keeps a saturating count of stalled (IF-frozen) cycles and a
// sticky error flag raised when a memory access times out.
//
// Parameters
//   REG_W    register-index width
//   TIMEOUT  number of wait-counter steps allowed in WAIT before abort
//   CNT_W    width of the stall-cycle counter
//
// Ports
//   clk, rst                     clock (rising edge), sync active-high reset
//   id_src1, id_src2, id_two_src source registers of the ID instruction
//   exe_wb_en, exe_dest,
//   exe_mem_read                 EXE instruction write-back / load info
//   mem_wb_en, mem_dest          MEM instruction write-back info
//   fwd_en                       forwarding unit enabled
//   branch_taken                 EXE resolved a taken branch
//   mem_req, mem_ready           memory access request / completion pulse
//   mem_start                    1-cycle request pulse to memory controller
//   if_freeze .. mem_freeze      hold the corresponding stage registers
//   if_flush, id_flush           zero IF/ID, insert bubble into ID/EX
//   hazard                       raw data-hazard detection
//   mem_err                      sticky memory-timeout flag
//   stall_cnt                    saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic             exe_wb_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_mem_read,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             mem_start,
  output logic             if_freeze,
  output logic             id_freeze,
  output logic             exe_freeze,
  output logic             mem_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             hazard,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // Wait counter must be able to hold the value TIMEOUT itself.
  localparam int WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(TIMEOUT);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_start_q, mem_start_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic ex_m1, ex_m2, mem_m1, mem_m2;
  logic ex_match, any_match;
  logic timeout_hit;
  logic mem_busy;

  // -------------------------------------------------------------------------
  // Data-hazard detection (purely combinational on the current operands)
  // -------------------------------------------------------------------------
  always_comb begin
    ex_m1  = exe_wb_en & (exe_dest == id_src1);
    ex_m2  = exe_wb_en & id_two_src & (exe_dest == id_src2);
    mem_m1 = mem_wb_en & (mem_dest == id_src1);
    mem_m2 = mem_wb_en & id_two_src & (mem_dest == id_src2);

    ex_match  = ex_m1 | ex_m2;
    any_match = ex_match | mem_m1 | mem_m2;

    // With forwarding only a load in EXE cannot be bypassed in time
    // (load-use); every other dependency is covered by the forwarding paths.
    if (fwd_en) begin
      hazard = exe_mem_read & ex_match;
    end else begin
      hazard = any_match;
    end
  end

  // -------------------------------------------------------------------------
  // Memory FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_start_d = 1'b0;
    mem_err_d   = mem_err_q;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        // mem_ready here is a stray pulse and is deliberately ignored.
        if (mem_req) begin
          state_d     = S_WAIT;
          wait_cnt_d  = '0;
          mem_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == TIMEOUT_V) begin
          timeout_hit = 1'b1;
          mem_err_d   = 1'b1;
          state_d     = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // The completion and abort cycles are not frozen, so the pipeline
  // advances on the same edge that the FSM drops back to IDLE.
  assign mem_busy = ((state_q == S_IDLE) & mem_req) |
                    ((state_q == S_WAIT) & ~mem_ready & ~timeout_hit);

  // -------------------------------------------------------------------------
  // Freeze / flush priority: memory stall > taken branch > data hazard
  // -------------------------------------------------------------------------
  always_comb begin
    if_freeze  = 1'b0;
    id_freeze  = 1'b0;
    exe_freeze = 1'b0;
    mem_freeze = 1'b0;
    if_flush   = 1'b0;
    id_flush   = 1'b0;

    if (mem_busy) begin
      // Whole pipe holds; a branch seen now stays in frozen EXE and is
      // acted on in the release cycle.
      if_freeze  = 1'b1;
      id_freeze  = 1'b1;
      exe_freeze = 1'b1;
      mem_freeze = 1'b1;
    end else if (branch_taken) begin
      // The hazarded ID instruction is on the wrong path, so just squash.
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (hazard) begin
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end
  end

  assign stall_cnt_d = if_freeze ? sat_inc(stall_cnt_q) : stall_cnt_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_start_q <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_start_q <= mem_start_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_start = mem_start_q;
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl, built with TIMEOUT=3 and CNT_W=4
// so the timeout abort and the stall-counter saturation are reachable in a
// handful of cycles. Inputs change 1 time unit after the rising edge and
// outputs are sampled 1-2 units later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int REG_W   = 4;
  localparam int TIMEOUT = 3;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_src1, id_src2;
  logic             id_two_src;
  logic             exe_wb_en;
  logic [REG_W-1:0] exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             fwd_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             mem_start;
  logic             if_freeze, id_freeze, exe_freeze, mem_freeze;
  logic             if_flush, id_flush;
  logic             hazard;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_two_src   (id_two_src),
    .exe_wb_en    (exe_wb_en),
    .exe_dest     (exe_dest),
    .exe_mem_read (exe_mem_read),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .fwd_en       (fwd_en),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .mem_start    (mem_start),
    .if_freeze    (if_freeze),
    .id_freeze    (id_freeze),
    .exe_freeze   (exe_freeze),
    .mem_freeze   (mem_freeze),
    .if_flush     (if_flush),
    .id_flush     (id_flush),
    .hazard       (hazard),
    .mem_err      (mem_err),
    .stall_cnt    (stall_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_inputs();
    id_src1      = '0;
    id_src2      = '0;
    id_two_src   = 1'b0;
    exe_wb_en    = 1'b0;
    exe_dest     = '0;
    exe_mem_read = 1'b0;
    mem_wb_en    = 1'b0;
    mem_dest     = '0;
    fwd_en       = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr_inputs();
    step();
    step();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_mem_err",   int'(mem_err),   0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_mem_start", int'(mem_start), 0);
    chk("rst_if_freeze", int'(if_freeze), 0);

    // ---------------- load-use with forwarding ----------------
    fwd_en = 1'b1; exe_mem_read = 1'b1; exe_wb_en = 1'b1;
    exe_dest = 4'd3; id_src1 = 4'd3;
    settle();
    chk("lu_hazard",     int'(hazard),     1);
    chk("lu_if_freeze",  int'(if_freeze),  1);
    chk("lu_id_flush",   int'(id_flush),   1);
    chk("lu_exe_freeze", int'(exe_freeze), 0);
    chk("lu_if_flush",   int'(if_flush),   0);
    step();
    chk("lu_stall_cnt",  int'(stall_cnt),  1);
    exe_mem_read = 1'b0;
    settle();
    chk("nolu_hazard",    int'(hazard),    0);
    chk("nolu_if_freeze", int'(if_freeze), 0);
    // MEM match is covered by forwarding
    mem_wb_en = 1'b1; mem_dest = 4'd3;
    settle();
    chk("fwd_mem_hazard", int'(hazard), 0);
    step();
    chk("fwd_stall_hold", int'(stall_cnt), 1);

    // ---------------- no forwarding ----------------
    do_reset();
    mem_wb_en = 1'b1; mem_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b0;
    settle();
    chk("nf_one_src_hazard", int'(hazard), 0);
    id_two_src = 1'b1;
    settle();
    chk("nf_two_src_hazard", int'(hazard),    1);
    chk("nf_two_src_freeze", int'(if_freeze), 1);
    clr_inputs();
    exe_wb_en = 1'b1; exe_dest = 4'd7; id_src1 = 4'd7;
    settle();
    chk("nf_exe_hazard", int'(hazard), 1);
    exe_wb_en = 1'b0;
    settle();
    chk("nf_no_wb_hazard", int'(hazard), 0);

    // ---------------- branch vs hazard ----------------
    do_reset();
    exe_wb_en = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2; branch_taken = 1'b1;
    settle();
    chk("br_hazard",    int'(hazard),    1);
    chk("br_if_flush",  int'(if_flush),  1);
    chk("br_id_flush",  int'(id_flush),  1);
    chk("br_if_freeze", int'(if_freeze), 0);
    step();
    chk("br_stall_cnt", int'(stall_cnt), 0);

    // ---------------- memory handshake ----------------
    do_reset();
    mem_req = 1'b1;                                  // cycle 0
    settle();
    chk("hs0_if_freeze",  int'(if_freeze),  1);
    chk("hs0_id_freeze",  int'(id_freeze),  1);
    chk("hs0_exe_freeze", int'(exe_freeze), 1);
    chk("hs0_mem_freeze", int'(mem_freeze), 1);
    chk("hs0_mem_start",  int'(mem_start),  0);
    step();                                          // cycle 1
    chk("hs1_mem_start",  int'(mem_start),  1);
    branch_taken = 1'b1;
    settle();
    chk("hs1_br_if_flush", int'(if_flush), 0);
    chk("hs1_br_id_flush", int'(id_flush), 0);
    step();                                          // cycle 2
    branch_taken = 1'b0;
    chk("hs2_mem_start",  int'(mem_start),  0);
    chk("hs2_mem_freeze", int'(mem_freeze), 1);
    step();                                          // cycle 3
    step();                                          // cycle 4
    mem_ready = 1'b1; branch_taken = 1'b1;
    settle();
    chk("hs4_if_freeze",  int'(if_freeze),  0);
    chk("hs4_exe_freeze", int'(exe_freeze), 0);
    chk("hs4_mem_freeze", int'(mem_freeze), 0);
    chk("hs4_br_if_flush", int'(if_flush),  1);
    step();                                          // cycle 5
    mem_ready = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
    settle();
    chk("hs5_stall_cnt",  int'(stall_cnt),  4);
    chk("hs5_mem_freeze", int'(mem_freeze), 0);
    chk("hs5_mem_err",    int'(mem_err),    0);

    // stray mem_ready in IDLE is ignored
    mem_ready = 1'b1;
    settle();
    chk("idle_rdy_freeze", int'(mem_freeze), 0);
    step();
    mem_ready = 1'b0;
    settle();
    chk("idle_rdy_start",  int'(mem_start),  0);
    chk("idle_rdy_freeze2", int'(mem_freeze), 0);

    // ---------------- timeout ----------------
    mem_req = 1'b1;
    step();                                          // WAIT cycle 1
    mem_req = 1'b0;
    settle();
    chk("to_w1_start",  int'(mem_start),  1);
    chk("to_w1_freeze", int'(mem_freeze), 1);
    step();                                          // WAIT cycle 2
    step();                                          // WAIT cycle 3
    chk("to_w3_freeze", int'(mem_freeze), 1);
    step();                                          // WAIT cycle 4: abort
    chk("to_w4_freeze", int'(mem_freeze), 0);
    chk("to_w4_err",    int'(mem_err),    0);
    step();                                          // back in IDLE
    chk("to_err_set",     int'(mem_err),    1);
    chk("to_idle_freeze", int'(mem_freeze), 0);
    // further traffic keeps the sticky flag
    mem_req = 1'b1;
    step();
    mem_req = 1'b0; mem_ready = 1'b1;
    settle();
    chk("to_traffic_freeze", int'(mem_freeze), 0);
    step();
    mem_ready = 1'b0;
    chk("to_err_sticky", int'(mem_err), 1);

    // ---------------- reset mid-WAIT ----------------
    mem_req = 1'b1;
    step();                                          // WAIT, mem_start=1
    step();                                          // WAIT, counting
    rst = 1'b1;
    step();
    rst = 1'b0; mem_req = 1'b0;
    settle();
    chk("rw_mem_start",  int'(mem_start),  0);
    chk("rw_stall_cnt",  int'(stall_cnt),  0);
    chk("rw_mem_err",    int'(mem_err),    0);
    chk("rw_mem_freeze", int'(mem_freeze), 0);
    // reset overrides a request seen in IDLE
    mem_req = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; mem_req = 1'b0;
    settle();
    chk("rr_mem_start",  int'(mem_start),  0);
    chk("rr_mem_freeze", int'(mem_freeze), 0);

    // ---------------- stall counter saturation ----------------
    do_reset();
    exe_wb_en = 1'b1; exe_dest = 4'd9; id_src1 = 4'd9;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", int'(stall_cnt), 14);
    step();
    chk("sat_15", int'(stall_cnt), 15);
    for (int i = 0; i < 5; i++) step();
    chk("sat_20", int'(stall_cnt), 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It generates freeze/flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It resolves three sources of disruption: data hazards (with or without forwarding), taken branches, and multi-cycle data-memory accesses through a start/ready handshake with the memory controller. It also keeps a saturating stall-cycle counter and a sticky memory-timeout error flag.

Parameters:
REG_W, 4, register-index width
TIMEOUT, 255, max cycles in WAIT before abort
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
id_src1  in  REG_W  first source register of the instruction in ID
id_src2  in  REG_W  second source register of the instruction in ID
id_two_src  in  1  ID instruction reads id_src2
exe_wb_en  in  1  EXE instruction writes a register
exe_dest  in  REG_W  EXE destination register
exe_mem_read  in  1  EXE instruction is a load
mem_wb_en  in  1  MEM instruction writes a register
mem_dest  in  REG_W  MEM destination register
fwd_en  in  1  forwarding unit enabled
branch_taken  in  1  EXE resolved a taken branch
mem_req  in  1  MEM stage holds a load/store
mem_ready  in  1  memory controller completion, 1-cycle pulse
mem_start  out  1  1-cycle request pulse to memory controller
if_freeze  out  1  hold PC and IF/ID
id_freeze  out  1  hold ID/EX
exe_freeze  out  1  hold EX/MEM
mem_freeze  out  1  hold MEM/WB
if_flush  out  1  zero IF/ID
id_flush  out  1  zero ID/EX (insert bubble)
hazard  out  1  data hazard detected this cycle
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst high at a rising edge): FSM goes to IDLE; mem_err=0, stall_cnt=0, wait counter=0, mem_start=0. Rst overrides all other inputs, including when asserted mid-WAIT; the pending access is abandoned.
- Memory FSM states:
  - IDLE: if mem_req=1, go to WAIT next cycle and assert mem_start (registered) for exactly that first WAIT cycle.
  - WAIT: if mem_ready=1, go to IDLE. Otherwise, if the wait counter equals TIMEOUT, set mem_err=1 and go to IDLE. Otherwise increment the wait counter. The wait counter is cleared on entry to WAIT.
  - A mem_ready pulse in IDLE is ignored.
- mem_busy (combinational) = (IDLE & mem_req) | (WAIT & ~mem_ready & ~timeout_hit).
  - While mem_busy=1: if_freeze, id_freeze, exe_freeze and mem_freeze are all 1, and if_flush and id_flush are forced to 0.
  - The completion cycle (WAIT & mem_ready) is not frozen, so the pipeline advances on the same edge that the FSM returns to IDLE.
  - A new mem_req one cycle after completion starts a new access normally.
- Hazard (combinational):
  - m1 = exe_wb_en & (exe_dest==id_src1); m2 = mem_wb_en & (mem_dest==id_src1). The id_src2 compares are identical but gated by id_two_src.
  - fwd_en=0: hazard = any match against EXE or MEM.
  - fwd_en=1: hazard = exe_mem_read & exe_wb_en & EXE match only.
- Priority when mem_busy=0:
  - branch_taken=1: if_flush=1, id_flush=1, no freeze. The branch overrides the hazard, because the hazarded instruction is discarded.
  - else hazard=1: if_freeze=1, id_flush=1.
  - else all controls are 0.
- exe_freeze and mem_freeze are asserted only by mem_busy.
- A branch_taken arriving during mem_busy is not acted on. EXE is frozen, so it re-presents the branch and it is handled on the release cycle.
- stall_cnt increments by 1 on every cycle where if_freeze=1. It saturates at all-ones and never wraps.
- mem_err is cleared only by rst.
- The hazard output reflects the raw detection even when masked by mem_busy or branch_taken.

Test Plan:
- Load-use: fwd_en=1, exe_mem_read=1, exe_wb_en=1, exe_dest=3, id_src1=3 -> hazard=1, if_freeze=1, id_flush=1, exe_freeze=0. Same stimulus with exe_mem_read=0 -> hazard=0.
- No forwarding: fwd_en=0, mem_wb_en=1, mem_dest=5, id_src2=5, id_two_src=0 -> hazard=0. Set id_two_src=1 -> hazard=1.
- Branch vs hazard: branch_taken=1 together with a hazard -> if_flush=1, id_flush=1, if_freeze=0, stall_cnt unchanged.
- Memory handshake: mem_req at cycle 0 -> all freezes=1 in cycle 0; mem_start=1 in cycle 1 only; mem_ready pulse at cycle 4 -> freezes=0 in cycle 4, IDLE at cycle 5, stall_cnt=4.
- Timeout with TIMEOUT=3 and mem_ready never asserted -> mem_err=1 after 4 WAIT cycles, FSM back in IDLE. mem_err stays 1 through further traffic until rst.
- Reset mid-WAIT and saturation: rst during WAIT -> IDLE, stall_cnt=0, mem_start=0. With CNT_W=4 and 20 stall cycles -> stall_cnt=15.
